// File: rtl/matrix_pkg.sv
// Constants, FSM state type and lane helper shared by the MAC ALU and its
// result write-back stage.
package matrix_pkg;

    localparam int DATA_W    = 20;
    localparam int NUM_LANES = 7;
    localparam int NUM_COLS  = 8;
    localparam int LANE_W    = $clog2(NUM_LANES);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } wb_state_t;

    // Lane index 0 selects lane 1, which sits in the MSBs of the packed vector.
    function automatic logic [DATA_W-1:0] lane_extract(
        input logic [NUM_LANES*DATA_W-1:0] vec,
        input logic [LANE_W-1:0]           idx
    );
        logic [DATA_W-1:0] word_s;
        word_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_LANES; i++) begin
            if (idx == LANE_W'(i)) begin
                word_s = vec[(NUM_LANES-1-i)*DATA_W +: DATA_W];
            end
        end
        return word_s;
    endfunction

endpackage

// File: rtl/wb_bank_buf.sv
// Two-bank ping-pong storage for captured lane results, with a capture
// write port and a lane-select read mux.
module wb_bank_buf
    import matrix_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic                        wr_sel,
    input  logic [NUM_LANES*DATA_W-1:0] wr_data,
    input  logic                        rd_sel,
    input  logic [LANE_W-1:0]           rd_lane,
    output logic [DATA_W-1:0]           rd_data
);

    logic [1:0][NUM_LANES*DATA_W-1:0] bank_r;

    // Capture write into the selected bank; contents cleared on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_r <= {2*NUM_LANES*DATA_W{1'b0}};
        end else if (wr_en) begin
            bank_r[wr_sel] <= wr_data;
        end else begin
            bank_r <= bank_r;
        end
    end

    assign rd_data = lane_extract(bank_r[rd_sel], rd_lane);

endmodule

// File: rtl/result_writeback.sv
// Captures 7-lane ALU results into a ping-pong buffer and drains them one
// word per cycle into the result SRAM, tolerating back-pressure.
module result_writeback #(
    parameter int DATA_W    = matrix_pkg::DATA_W,
    parameter int NUM_LANES = matrix_pkg::NUM_LANES,
    parameter int NUM_COLS  = matrix_pkg::NUM_COLS,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cap_valid,
    input  logic [NUM_LANES*DATA_W-1:0] mu_in,
    input  logic                        ram_ready,
    output logic                        cap_ready,
    output logic                        ram_we,
    output logic [ADDR_W-1:0]           ram_addr,
    output logic [DATA_W-1:0]           ram_wdata,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow
);

    import matrix_pkg::*;

    localparam int LANE_IDX_W = $clog2(NUM_LANES);
    localparam int COL_W      = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

    wb_state_t             state_r;
    logic [1:0]            occ_r;
    logic                  wr_bank_r;
    logic                  rd_bank_r;
    logic [LANE_IDX_W-1:0] lane_r;
    logic [COL_W-1:0]      col_r;
    logic                  done_r;
    logic                  overflow_r;

    logic                  cap_fire_s;
    logic                  accept_s;
    logic                  release_s;
    logic [1:0]            occ_next_s;

    // Handshake decode and next occupancy; a bank freed this cycle is not
    // offered to a capture in the same cycle because cap_fire_s uses occ_r.
    always_comb begin
        cap_fire_s = cap_valid && (occ_r < 2'd2);
        accept_s   = (state_r == DRAIN) && ram_ready;
        release_s  = accept_s && (lane_r == LANE_IDX_W'(NUM_LANES-1));
        if (cap_fire_s && !release_s) begin
            occ_next_s = occ_r + 2'd1;
        end else if (!cap_fire_s && release_s) begin
            occ_next_s = occ_r - 2'd1;
        end else begin
            occ_next_s = occ_r;
        end
    end

    // Drain FSM with pointers, counters and registered status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            occ_r      <= 2'd0;
            wr_bank_r  <= 1'b0;
            rd_bank_r  <= 1'b0;
            lane_r     <= {LANE_IDX_W{1'b0}};
            col_r      <= {COL_W{1'b0}};
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            occ_r      <= occ_next_s;
            wr_bank_r  <= cap_fire_s ? ~wr_bank_r : wr_bank_r;
            overflow_r <= overflow_r || (cap_valid && !cap_fire_s);
            done_r     <= release_s && (col_r == COL_W'(NUM_COLS-1));

            if (release_s) begin
                lane_r    <= {LANE_IDX_W{1'b0}};
                rd_bank_r <= ~rd_bank_r;
                col_r     <= (col_r == COL_W'(NUM_COLS-1)) ? {COL_W{1'b0}} : col_r + COL_W'(1);
            end else if (accept_s) begin
                lane_r <= lane_r + LANE_IDX_W'(1);
            end else begin
                lane_r <= lane_r;
            end

            case (state_r)
                IDLE:    state_r <= (occ_next_s != 2'd0) ? DRAIN : IDLE;
                DRAIN:   state_r <= (occ_next_s == 2'd0) ? IDLE : DRAIN;
                default: state_r <= IDLE;
            endcase
        end
    end

    wb_bank_buf u_bank_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (cap_fire_s),
        .wr_sel  (wr_bank_r),
        .wr_data (mu_in),
        .rd_sel  (rd_bank_r),
        .rd_lane (lane_r),
        .rd_data (ram_wdata)
    );

    assign ram_addr  = ADDR_W'(BASE_ADDR + int'(col_r) * NUM_LANES + int'(lane_r));
    assign ram_we    = (state_r == DRAIN);
    assign cap_ready = (occ_r < 2'd2);
    assign busy      = (occ_r != 2'd0);
    assign done      = done_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_result_writeback.sv
// Directed self-checking bench for result_writeback: single capture, full
// matrix, back-pressure, bank overflow, capture-on-release and mid-drain reset.
module tb_result_writeback;

    logic         clk = 1'b0;
    logic         rst;
    logic         cap_valid;
    logic [139:0] mu_in;
    logic         ram_ready;
    logic         cap_ready;
    logic         ram_we;
    logic [7:0]   ram_addr;
    logic [19:0]  ram_wdata;
    logic         busy;
    logic         done;
    logic         overflow;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    result_writeback dut (
        .clk       (clk),
        .rst       (rst),
        .cap_valid (cap_valid),
        .mu_in     (mu_in),
        .ram_ready (ram_ready),
        .cap_ready (cap_ready),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word currently presented: {we, addr, data}.
    task automatic wchk(input string tag, input int addr, input int data);
        chk(tag, {3'b000, ram_we, ram_addr, ram_wdata}, {3'b000, 1'b1, addr[7:0], data[19:0]});
    endtask

    function automatic logic [139:0] mk_mu(input int base);
        logic [139:0] v;
        v = 140'd0;
        for (int l = 0; l < 7; l++) v[(6-l)*20 +: 20] = 20'(base + l + 1);
        return v;
    endfunction

    task automatic capture(input int base);
        cap_valid = 1'b1;
        mu_in     = mk_mu(base);
        tick();
        cap_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst       = 1'b0;
        cap_valid = 1'b0;
        mu_in     = 140'd0;
        ram_ready = 1'b1;
        #12;
        chk("rst_outputs", {ram_we, busy, done, overflow, cap_ready, ram_addr, ram_wdata},
            {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 20'd0});
        tick();
        rst = 1'b1;
        tick();

        // Single capture, lanes 1..7
        capture(0);
        for (int l = 0; l < 7; l++) begin
            wchk("single_word", l, l + 1);
            tick();
        end
        chk("single_idle", {ram_we, busy, cap_ready}, {1'b0, 1'b0, 1'b1});

        // Full matrix: 8 columns spaced 8 cycles
        do_reset();
        for (int c = 0; c < 8; c++) begin
            capture(16 * c);
            for (int l = 0; l < 7; l++) begin
                wchk("matrix_word", c * 7 + l, 16 * c + l + 1);
                chk("matrix_no_done", {31'd0, done}, 32'd0);
                tick();
            end
            chk("matrix_done", {31'd0, done}, (c == 7) ? 32'd1 : 32'd0);
        end
        tick();
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        capture(768);
        wchk("col_wrap", 0, 769);
        for (int l = 0; l < 7; l++) tick();

        // Back-pressure at the third word
        do_reset();
        capture(100);
        wchk("bp_w0", 0, 101);
        tick();
        wchk("bp_w1", 1, 102);
        tick();
        ram_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wchk("bp_hold", 2, 103);
            tick();
        end
        ram_ready = 1'b1;
        for (int l = 2; l < 7; l++) begin
            wchk("bp_resume", l, 101 + l);
            tick();
        end
        chk("bp_idle", {31'd0, busy}, 32'd0);

        // Fill both banks, then overflow
        do_reset();
        ram_ready = 1'b0;
        capture(200);
        chk("fill_ready1", {31'd0, cap_ready}, 32'd1);
        capture(300);
        chk("fill_ready0", {31'd0, cap_ready}, 32'd0);
        chk("fill_no_ovf", {31'd0, overflow}, 32'd0);
        capture(400);
        chk("fill_ovf", {30'd0, overflow, cap_ready}, {30'd0, 1'b1, 1'b0});
        ram_ready = 1'b1;
        for (int l = 0; l < 14; l++) begin
            wchk("fill_word", l, (l < 7) ? 201 + l : 301 + (l - 7));
            tick();
        end
        chk("fill_idle", {30'd0, busy, overflow}, {30'd0, 1'b0, 1'b1});

        // Mid-drain reset with both banks occupied (col is 2 here)
        capture(500);
        wchk("mid_w0", 14, 501);
        cap_valid = 1'b1;
        mu_in     = mk_mu(600);
        tick();
        cap_valid = 1'b0;
        for (int l = 1; l < 4; l++) begin
            wchk("mid_word", 14 + l, 501 + l);
            tick();
        end
        wchk("mid_lane4", 18, 505);
        rst = 1'b0;
        #1;
        chk("mid_rst", {ram_we, busy, overflow, done, cap_ready, ram_addr},
            {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0});
        tick();
        rst = 1'b1;
        tick();
        capture(700);
        for (int l = 0; l < 7; l++) begin
            wchk("post_rst_word", l, 701 + l);
            tick();
        end
        chk("post_rst_idle", {31'd0, busy}, 32'd0);

        // Capture coincident with last-word accept, occ=1
        do_reset();
        capture(800);
        for (int l = 0; l < 6; l++) begin
            wchk("sim_a_word", l, 801 + l);
            tick();
        end
        wchk("sim_a_last", 6, 807);
        chk("sim_ready", {31'd0, cap_ready}, 32'd1);
        cap_valid = 1'b1;
        mu_in     = mk_mu(900);
        tick();
        cap_valid = 1'b0;
        chk("sim_busy", {30'd0, busy, cap_ready}, {30'd0, 1'b1, 1'b1});
        for (int l = 0; l < 7; l++) begin
            wchk("sim_b_word", 7 + l, 901 + l);
            tick();
        end
        chk("sim_idle", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
